// File: rtl/anim_sched_pkg.sv
// Shared definitions for the LED animation scheduler.
// Holds the mode encodings, the frame lengths, the control FSM state type and the
// pattern lookup used for the (mode, index) to LED byte mapping.
package anim_pkg;

  localparam logic [1:0] MODE_BAR    = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam int unsigned LEN_BAR    = 16;
  localparam int unsigned LEN_CHASE  = 8;
  localparam int unsigned LEN_BOUNCE = 14;
  localparam int unsigned LEN_BLINK  = 2;

  typedef enum logic [0:0] {StRun, StArmed} ctrl_state_e;

  // Last valid frame index (L-1) for a mode.
  function automatic logic [3:0] frame_last(input logic [1:0] mode);
    logic [3:0] last;
    unique case (mode)
      MODE_BAR:    last = 4'(LEN_BAR - 1);
      MODE_CHASE:  last = 4'(LEN_CHASE - 1);
      MODE_BOUNCE: last = 4'(LEN_BOUNCE - 1);
      default:     last = 4'(LEN_BLINK - 1);
    endcase
    return last;
  endfunction

  function automatic logic [7:0] anim_pattern(input logic [1:0] mode, input logic [3:0] idx);
    logic [8:0] ramp;
    logic [7:0] pat;
    ramp = 9'd0;
    pat  = 8'h00;
    unique case (mode)
      MODE_BAR: begin
        // Rising fill for the first half, draining fill for the second half.
        if (!idx[3]) ramp = (9'd1 << (idx + 4'd1)) - 9'd1;
        else         ramp = (9'd1 << (4'd15 - idx)) - 9'd1;
        pat = ramp[7:0];
      end
      MODE_CHASE:  pat = 8'd1 << idx[2:0];
      MODE_BOUNCE: pat = idx[3] ? (8'd1 << (4'd14 - idx)) : (8'd1 << idx[2:0]);
      default:     pat = idx[0] ? 8'h00 : 8'hFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/anim_sched_if.sv
// Control/status bundle of the animation scheduler.
// master: board-level controller (drives requests, divider, pause).
// slave:  anim_sched (drives handshake ready, LED pattern and status pulses).
interface anim_sched_if #(
  parameter int unsigned DIV_W = 16
);
  logic [1:0]       mode_req;
  logic             mode_valid;
  logic             mode_ready;
  logic             div_load;
  logic [DIV_W-1:0] div_val;
  logic             pause;
  logic [7:0]       led_out;
  logic [1:0]       mode_cur;
  logic             step;
  logic             frame_done;

  modport master (
    output mode_req, mode_valid, div_load, div_val, pause,
    input  mode_ready, led_out, mode_cur, step, frame_done
  );

  modport slave (
    input  mode_req, mode_valid, div_load, div_val, pause,
    output mode_ready, led_out, mode_cur, step, frame_done
  );
endinterface

// File: rtl/anim_timebase.sv
// Programmable step prescaler.
// Ports: clk/rst; div_load/div_val reload the divider and restart the period;
// pause freezes the counter; tick is high in the cycle whose edge performs a step.
module anim_timebase #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  input  logic             pause,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] One    = DIV_W'(1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             terminal;

  assign terminal = (cnt_q == div_q - One);
  // A load in the same cycle swallows the terminal count.
  assign tick     = terminal && !pause && !div_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DefDiv;
      cnt_q <= '0;
    end else if (div_load) begin
      div_q <= (div_val == '0) ? One : div_val;
      cnt_q <= '0;
    end else if (!pause) begin
      cnt_q <= terminal ? '0 : cnt_q + One;
    end
  end

endmodule

// File: rtl/anim_sched.sv
// Scheduler for the 8-LED animation: frame index, mode-change handshake and the
// registered LED/status outputs. Ports: clk, rst and the slave side of anim_sched_if
// (mode request handshake, divider load, pause, led_out, mode_cur, step, frame_done).
module anim_sched
  import anim_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEF_DIV = 4
) (
  input logic        clk,
  input logic        rst,
  anim_sched_if.slave bus
);

  logic        tick;
  logic        frame_end;
  ctrl_state_e state_q, state_d;
  logic [1:0]  pending_q, pending_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  led_q, led_d;
  logic        step_q, step_d;
  logic        fd_q, fd_d;

  anim_timebase #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .div_load (bus.div_load),
    .div_val  (bus.div_val),
    .pause    (bus.pause),
    .tick     (tick)
  );

  assign frame_end = tick && (idx_q == frame_last(mode_q));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    led_d     = led_q;
    step_d    = 1'b0;
    fd_d      = 1'b0;

    if (tick) begin
      step_d = 1'b1;
      if (frame_end) begin
        fd_d  = 1'b1;
        idx_d = 4'd0;
        // Switch uses the request held from before this edge, never one arriving now.
        if (state_q == StArmed) mode_d = pending_q;
      end else begin
        idx_d = idx_q + 4'd1;
      end
      led_d = anim_pattern(mode_d, idx_d);
    end

    unique case (state_q)
      StRun: begin
        if (bus.mode_valid) begin
          pending_d = bus.mode_req;
          state_d   = StArmed;
        end
      end
      StArmed: begin
        if (frame_end) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      pending_q <= MODE_BAR;
      mode_q    <= MODE_BAR;
      idx_q     <= 4'd0;
      led_q     <= 8'h01;
      step_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      led_q     <= led_d;
      step_q    <= step_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.mode_ready = (state_q == StRun);
  assign bus.led_out    = led_q;
  assign bus.mode_cur   = mode_q;
  assign bus.step       = step_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_anim_sched.sv
module tb_anim_sched;
  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 4;

  localparam logic [7:0] BAR_T [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                        8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
  localparam logic [7:0] BNC_T [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
  localparam int LEN [4] = '{16, 8, 14, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  anim_sched_if #(.DIV_W(DIV_W)) bus ();

  anim_sched #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: step period counted in cycles, one-deep request queue.
  int         m_div, m_phase, m_idx, m_mode;
  int         m_pend[$];
  logic [7:0] e_led;
  logic       e_step, e_fd;

  function automatic logic [7:0] ref_pat(int m, int i);
    case (m)
      0:       return BAR_T[i];
      1:       return 8'(1 << i);
      2:       return BNC_T[i];
      default: return (i == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  function automatic logic [12:0] expv();
    return {e_led, e_step, e_fd, (m_pend.size() == 0), 2'(m_mode)};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.led_out, bus.step, bus.frame_done, bus.mode_ready, bus.mode_cur};
  endfunction

  task automatic model_reset();
    m_div = DEF_DIV; m_phase = 0; m_idx = 0; m_mode = 0;
    m_pend.delete();
    e_led = 8'h01; e_step = 1'b0; e_fd = 1'b0;
  endtask

  task automatic model_edge();
    bit ready_now;
    ready_now = (m_pend.size() == 0);
    e_step = 1'b0;
    e_fd   = 1'b0;
    if (bus.div_load) begin
      m_div   = (bus.div_val == 0) ? 1 : int'(bus.div_val);
      m_phase = 0;
    end else if (!bus.pause) begin
      m_phase++;
      if (m_phase >= m_div) begin
        m_phase = 0;
        e_step  = 1'b1;
      end
    end
    if (e_step) begin
      if (m_idx == LEN[m_mode] - 1) begin
        e_fd  = 1'b1;
        m_idx = 0;
        if (m_pend.size() != 0) m_mode = m_pend.pop_front();
      end else begin
        m_idx++;
      end
      e_led = ref_pat(m_mode, m_idx);
    end
    if (bus.mode_valid && ready_now) m_pend.push_back(int'(bus.mode_req));
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.mode_valid = 1'b0; bus.mode_req = 2'd0;
    bus.div_load = 1'b0; bus.div_val = '0; bus.pause = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (obs() !== 13'({8'h01, 1'b0, 1'b0, 1'b1, 2'd0})) begin
      n_fail++; $display("FAIL reset_values: got %h want %h", obs(), expv());
    end
    rst = 1'b0;
  endtask

  task automatic test_bar();
    int steps = 0;
    for (int c = 1; c <= 70; c++) begin
      clk_cycle();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL bar cyc%0d: got %h want %h", c, obs(), expv());
      end
      if (bus.step) begin
        steps++;
        n_tests++;
        if ((steps == 1 && (c != 4 || bus.led_out !== 8'h03)) ||
            (steps == 2 && (c != 8 || bus.led_out !== 8'h07)) ||
            (steps == 7 && bus.led_out !== 8'hFF) ||
            (steps == 15 && bus.led_out !== 8'h00) ||
            (steps == 16 && (bus.led_out !== 8'h01 || bus.frame_done !== 1'b1))) begin
          n_fail++; $display("FAIL bar_step%0d: cyc %0d led %h fd %b", steps, c, bus.led_out,
                             bus.frame_done);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    int g;
    for (g = 0; g < 200 && !(e_step && m_idx == 5 && m_mode == 0); g++) clk_cycle();
    n_tests++;
    if (g == 200) begin n_fail++; $display("FAIL switch_wait: got timeout want idx5"); end
    bus.mode_valid = 1'b1; bus.mode_req = 2'd1;
    clk_cycle();
    idle();
    for (g = 0; g < 150; g++) begin
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL switch cyc%0d: got %h want %h", g, obs(), expv());
      end
      clk_cycle();
    end
    n_tests++;
    if (bus.mode_cur !== 2'd1) begin
      n_fail++; $display("FAIL switch_mode: got %0d want 1", bus.mode_cur);
    end
  endtask

  task automatic test_same_edge();
    int g, c;
    bus.mode_valid = 1'b1; bus.mode_req = 2'd2;
    clk_cycle();
    idle();
    for (g = 0; g < 300 && !(m_mode == 2 && m_idx == 13 && m_phase == m_div - 1); g++) begin
      clk_cycle();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL same_pre cyc%0d: got %h want %h", g, obs(), expv());
      end
    end
    bus.mode_valid = 1'b1; bus.mode_req = 2'd3;
    clk_cycle();
    idle();
    n_tests++;
    if (bus.frame_done !== 1'b1 || bus.mode_ready !== 1'b0 || bus.mode_cur !== 2'd2) begin
      n_fail++; $display("FAIL same_edge: got fd %b rdy %b mode %0d want 1 0 2",
                         bus.frame_done, bus.mode_ready, bus.mode_cur);
    end
    for (c = 0; c < 200 && bus.mode_cur !== 2'd3; c++) begin
      clk_cycle();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL same_frame cyc%0d: got %h want %h", c, obs(), expv());
      end
    end
    n_tests++;
    if (c != 56) begin n_fail++; $display("FAIL same_latency: got %0d want 56", c); end
    for (g = 0; g < 12; g++) begin
      clk_cycle();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL blink cyc%0d: got %h want %h", g, obs(), expv());
      end
    end
  endtask

  task automatic test_divider();
    int s, g;
    for (int v = 0; v < 2; v++) begin
      bus.div_load = 1'b1; bus.div_val = 16'(v);
      clk_cycle();
      idle();
      s = 0;
      for (g = 0; g < 5; g++) begin
        clk_cycle();
        if (bus.step) s++;
        n_tests++;
        if (obs() !== expv()) begin
          n_fail++; $display("FAIL div%0d cyc%0d: got %h want %h", v, g, obs(), expv());
        end
      end
      n_tests++;
      if (s != 5) begin n_fail++; $display("FAIL div%0d_rate: got %0d want 5", v, s); end
    end
    bus.div_load = 1'b1; bus.div_val = 16'd4;
    clk_cycle();
    idle();
    for (g = 0; g < 20 && m_phase != m_div - 1; g++) clk_cycle();
    bus.div_load = 1'b1; bus.div_val = 16'd3;
    clk_cycle();
    idle();
    n_tests++;
    if (bus.step !== 1'b0) begin n_fail++; $display("FAIL div_drop: got step 1 want 0"); end
    for (g = 1; g < 20; g++) begin
      clk_cycle();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL div3 cyc%0d: got %h want %h", g, obs(), expv());
      end
      if (bus.step) break;
    end
    n_tests++;
    if (g != 3) begin n_fail++; $display("FAIL div_period: got %0d want 3", g); end
  endtask

  task automatic test_pause();
    int g;
    logic [7:0] held;
    for (g = 0; g < 100 && m_pend.size() != 0; g++) clk_cycle();
    bus.mode_valid = 1'b1; bus.mode_req = 2'd1;
    clk_cycle();
    idle();
    for (g = 0; g < 200 && !(m_mode == 1 && m_idx == 3 && e_step); g++) clk_cycle();
    clk_cycle();
    held = e_led;
    bus.pause = 1'b1;
    for (g = 0; g < 10; g++) begin
      bus.mode_valid = (g == 2); bus.mode_req = 2'd2;
      clk_cycle();
      n_tests++;
      if (obs() !== expv() || bus.led_out !== held || bus.step !== 1'b0) begin
        n_fail++; $display("FAIL pause cyc%0d: got %h want %h", g, obs(), expv());
      end
    end
    idle();
    n_tests++;
    if (bus.mode_ready !== 1'b0) begin
      n_fail++; $display("FAIL pause_accept: got ready %b want 0", bus.mode_ready);
    end
    for (g = 1; g < 10; g++) begin
      clk_cycle();
      if (bus.step) break;
    end
    n_tests++;
    if (g != 2 || bus.led_out !== 8'h10) begin
      n_fail++; $display("FAIL pause_resume: got %0d/%h want 2/10", g, bus.led_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      bus.mode_valid = ($urandom_range(0, 7) == 0);
      bus.mode_req   = 2'($urandom_range(0, 3));
      bus.div_load   = ($urandom_range(0, 39) == 0);
      bus.div_val    = 16'($urandom_range(0, 5));
      bus.pause      = ($urandom_range(0, 5) == 0);
      clk_cycle();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random cyc%0d: got %h want %h", c, obs(), expv());
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    int g;
    for (g = 0; g < 100 && m_pend.size() != 0; g++) clk_cycle();
    bus.mode_valid = 1'b1; bus.mode_req = 2'd2;
    clk_cycle();
    idle();
    for (g = 0; g < 7; g++) clk_cycle();
    #2 rst = 1'b1;
    #1 model_reset();
    n_tests++;
    if (obs() !== 13'({8'h01, 1'b0, 1'b0, 1'b1, 2'd0})) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs(), expv());
    end
    @(negedge clk);
    rst = 1'b0;
    for (g = 0; g < 80; g++) begin
      clk_cycle();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL post_reset cyc%0d: got %h want %h", g, obs(), expv());
      end
    end
    n_tests++;
    if (bus.mode_cur !== 2'd0) begin
      n_fail++; $display("FAIL discard_pending: got mode %0d want 0", bus.mode_cur);
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_bar();
    test_mode_switch();
    test_same_edge();
    test_divider();
    test_pause();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/anim_sched.md
# anim_sched

Scheduler and timebase for the 8-LED animation datapath. It generates the step tick from a programmable prescaler and sequences one of four LED patterns: bar fill, chase, bounce and blink. It accepts pattern-change requests through a valid/ready handshake and applies them only at a frame boundary. It sits between the board-level control inputs and the LED output pins, and replaces the free-running fixed-pattern sequencing used so far.

## Interface
- `DIV_W`, 16: prescaler width in bits.
- `DEF_DIV`, 4: divider value after reset, in clk cycles per step; must be ≥1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mode_req` input 2: requested pattern (0 BAR, 1 CHASE, 2 BOUNCE, 3 BLINK).
- `mode_valid` input 1: `mode_req` is valid.
- `mode_ready` output 1: block can accept a mode request.
- `div_load` input 1: load the prescaler divider from `div_val`.
- `div_val` input DIV_W: new divider, in clk cycles per step.
- `pause` input 1: freeze the animation.
- `led_out` output 8: registered LED pattern.
- `mode_cur` output 2: pattern currently displayed.
- `step` output 1: one-cycle pulse, high in the first cycle a new `led_out` is shown.
- `frame_done` output 1: one-cycle pulse, high in the cycle the frame wraps to index 0.

## Operation
- **Prescaler**
  - Register `div` holds the divider; counter `cnt` runs 0..div-1.
  - At the edge where `cnt==div-1` and `pause==0`: `cnt` returns to 0 and a step occurs.
  - With `pause=1`, `cnt`, `idx` and `led_out` all hold; no step is issued.
- **Divider load**
  - `div_load=1`: `div` takes `div_val`, except that a `div_val` of 0 is stored as 1. `cnt` is cleared to 0 at the same edge.
  - Load has priority over a terminal count in the same cycle; that step is dropped.
- **Frame index and length**
  - `idx` is 4 bits. Frame length L depends on the mode: BAR 16, CHASE 8, BOUNCE 14, BLINK 2.
  - On each step: `idx` goes to `idx+1`, or to 0 when `idx==L-1` (frame end).
  - `led_out` gets the pattern for (mode, new `idx`) at that same edge.
- **Patterns** (bit 0 is the LSB)
  - BAR: for idx<8, (2^(idx+1))-1; for idx 8..15, (2^(15-idx))-1. This gives 01,03,...,FF,7F,...,01,00.
  - CHASE: 1<<idx.
  - BOUNCE: for idx<8, 1<<idx; for idx 8..13, 1<<(14-idx). This gives 01..80,40..02.
  - BLINK: FF, then 00.
- **Mode handshake**
  - A request is accepted when `mode_valid && mode_ready`. The value goes into register `pending`, and `mode_ready` drops at the next edge.
  - At a frame-end step with `pending` valid: `mode_cur` takes `pending`, `idx` goes to 0, `led_out` takes the pattern for (new mode, 0), `pending` is cleared, and `mode_ready` returns high at the next edge.
  - A request accepted on the same edge as a frame end is held and applied at the following frame end.
  - Requesting the current mode is legal; it restarts nothing early.
- **Control FSM states:** RUN (no pending request, `mode_ready=1`) and ARMED (request pending, `mode_ready=0`).
  - RUN to ARMED on an accepted request.
  - ARMED to RUN on a frame-end step.
  - `pause` does not affect FSM state.

## Timing
- **Reset values:** `div=DEF_DIV`, `cnt=0`, `idx=0`, `mode_cur=0`, `led_out=8'h01`, `step=0`, `frame_done=0`, `mode_ready=1`, `pending` empty. Reset mid-frame discards any pending request.
- First step occurs DEF_DIV cycles after reset deasserts.
- `step` and `frame_done` are registered and coincide with the `led_out` update. `frame_done` implies `step`.
- Mode latency: applied at the first frame-end step after acceptance, at most L×div cycles later. With `pause` held, latency is unbounded.
- `div=1`: a step every cycle. `div_load` restarts the step period from the load edge.

## Structure
- Package `anim_pkg` holds:
  - mode constants MODE_BAR, MODE_CHASE, MODE_BOUNCE, MODE_BLINK (2 bits);
  - frame-length constants;
  - function `anim_pattern(mode, idx)` returning 8 bits.
- Sub-module `anim_timebase` contains `div`, `cnt`, the `div_load` and `pause` logic, and produces the internal `tick`.
- `anim_sched` contains the index, the handshake FSM and the output registers.

## Test plan
- **Reset, BAR:** reset, DEF_DIV=4. Expect `led_out` 01 after reset. Then 03 at cycle 4, 07 at cycle 8; FF at step 7; 00 at step 15. Step 16 returns to 01 with `frame_done`.
- **Mode switch:** request CHASE mid-BAR at idx=5. Expect `mode_ready` low until frame end, BAR completes to 00, then 01 with `mode_cur=1` and `frame_done`, then 02, 04, ... 80, 01.
- **Same-edge request:** in BOUNCE, assert `mode_valid` with BLINK on the frame-end edge. Expect one more full BOUNCE frame (14 steps: 01..80,40..02), then FF/00 alternation.
- **Divider:** `div_val=0` then `div_val=1`. Expect a step every cycle in both cases. Then `div_load` with 3 on a terminal-count cycle: no step that cycle, and the next step comes 3 cycles later.
- **Pause:** `pause` for 10 cycles at idx=3. Expect `led_out` held, no `step`, and a request still accepted (`mode_ready` falls). After release, stepping resumes from the preserved `cnt`.
- **Async reset:** assert `rst` mid-cycle while a request is pending. Expect all outputs back to their reset values immediately, and the pending mode discarded.
